// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up in a final step.
module mdu_sequencer #(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  input  logic               i_flush,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_result,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam int NB_CNT = $clog2(NB_DATA);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

  localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(0);
  localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(1);
  localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(2);
  localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(3);
  localparam logic [NB_OP-1:0] OP_MFHI  = NB_OP'(4);
  localparam logic [NB_OP-1:0] OP_MFLO  = NB_OP'(5);
  localparam logic [NB_OP-1:0] OP_MTHI  = NB_OP'(6);
  localparam logic [NB_OP-1:0] OP_MTLO  = NB_OP'(7);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;

  state_t                 state_reg, state_next;
  logic [NB_CNT-1:0]      cnt_reg, cnt_next;
  logic [2*NB_DATA-1:0]   acc_reg, acc_next;
  logic [NB_DATA-1:0]     opnd_reg, opnd_next;
  logic                   is_div_reg, is_div_next;
  logic                   div0_reg, div0_next;
  logic                   sign_a_reg, sign_a_next;
  logic                   sign_b_reg, sign_b_next;
  logic [NB_DATA-1:0]     hi_reg, hi_next;
  logic [NB_DATA-1:0]     lo_reg, lo_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;

  // request decode
  logic is_mf_op, is_long_op, is_div_op, is_signed_op, accept;
  logic [NB_DATA-1:0] a_mag, b_mag;

  assign is_mf_op     = (i_op == OP_MFHI) || (i_op == OP_MFLO);
  assign is_div_op    = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign is_long_op   = (i_op == OP_MULT) || (i_op == OP_MULTU) || is_div_op;
  assign is_signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign a_mag = (is_signed_op && i_data_a[NB_DATA-1]) ? -i_data_a : i_data_a;
  assign b_mag = (is_signed_op && i_data_b[NB_DATA-1]) ? -i_data_b : i_data_b;

  assign o_stall  = i_start && (busy_reg || (is_mf_op && busy_reg));
  assign accept   = i_start && !o_stall && !i_flush;
  assign o_busy   = busy_reg;
  assign o_done   = done_reg;
  assign o_hi     = hi_reg;
  assign o_lo     = lo_reg;
  assign o_result = (i_op == OP_MFHI) ? hi_reg : lo_reg;

  // one multiply step: conditional add into the upper half, then shift right with carry
  logic [NB_DATA:0]     mul_sum;
  logic [2*NB_DATA-1:0] acc_mul;
  assign mul_sum = {1'b0, acc_reg[2*NB_DATA-1:NB_DATA]} + {1'b0, opnd_reg};
  assign acc_mul = acc_reg[0] ? {mul_sum, acc_reg[NB_DATA-1:1]}
                              : {1'b0, acc_reg[2*NB_DATA-1:1]};

  // one restoring-divide step: remainder upper half, dividend/quotient lower half
  logic [NB_DATA:0]     rem_sh;
  logic                 rem_ge;
  logic [NB_DATA-1:0]   rem_new;
  logic [2*NB_DATA-1:0] acc_div;
  assign rem_sh  = {acc_reg[2*NB_DATA-1:NB_DATA], acc_reg[NB_DATA-1]};
  assign rem_ge  = rem_sh >= {1'b0, opnd_reg};
  assign rem_new = rem_ge ? NB_DATA'(rem_sh - {1'b0, opnd_reg}) : rem_sh[NB_DATA-1:0];
  assign acc_div = {rem_new, acc_reg[NB_DATA-2:0], rem_ge};

  // sign fix-up; sign flags are already masked to zero for unsigned ops
  logic [2*NB_DATA-1:0] prod_fix;
  logic [NB_DATA-1:0]   quo_fix, rem_fix;
  assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
  assign quo_fix  = (sign_a_reg ^ sign_b_reg) ? -acc_reg[NB_DATA-1:0] : acc_reg[NB_DATA-1:0];
  assign rem_fix  = sign_a_reg ? -acc_reg[2*NB_DATA-1:NB_DATA] : acc_reg[2*NB_DATA-1:NB_DATA];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    opnd_next   = opnd_reg;
    is_div_next = is_div_reg;
    div0_next   = div0_reg;
    sign_a_next = sign_a_reg;
    sign_b_next = sign_b_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (i_op == OP_MTHI) begin
            hi_next = i_data_a;
          end else if (i_op == OP_MTLO) begin
            lo_next = i_data_a;
          end else if (is_long_op) begin
            is_div_next = is_div_op;
            sign_a_next = is_signed_op && i_data_a[NB_DATA-1];
            sign_b_next = is_signed_op && i_data_b[NB_DATA-1];
            div0_next   = is_div_op && (i_data_b == '0);
            cnt_next    = '0;
            busy_next   = 1'b1;
            if (is_div_op) begin
              opnd_next = b_mag;
              acc_next  = {{NB_DATA{1'b0}}, a_mag};
            end else begin
              opnd_next = a_mag;
              acc_next  = {{NB_DATA{1'b0}}, b_mag};
            end
            if (is_div_op && (i_data_b == '0)) begin
              // raw dividend parked in the upper half becomes HI
              acc_next   = {i_data_a, {NB_DATA{1'b0}}};
              state_next = ST_FIX;
            end else begin
              state_next = ST_CALC;
            end
          end
        end
      end
      ST_CALC: begin
        acc_next = is_div_reg ? acc_div : acc_mul;
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_FIX;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_FIX: begin
        if (!is_div_reg) begin
          hi_next = prod_fix[2*NB_DATA-1:NB_DATA];
          lo_next = prod_fix[NB_DATA-1:0];
        end else if (div0_reg) begin
          hi_next = acc_reg[2*NB_DATA-1:NB_DATA];
          lo_next = '1;
        end else begin
          hi_next = rem_fix;
          lo_next = quo_fix;
        end
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (i_flush) begin
      state_next = ST_IDLE;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      div0_reg   <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      opnd_reg   <= opnd_next;
      is_div_reg <= is_div_next;
      div0_reg   <= div0_next;
      sign_a_reg <= sign_a_next;
      sign_b_reg <= sign_b_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO model.
module tb_mdu_sequencer;

  localparam int N = 32;
  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MFHI = 3'd4, MFLO = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [N-1:0] a, b;
  logic         stall, busy, done;
  logic [N-1:0] result, hi, lo;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [N-1:0] m_hi, m_lo;

  mdu_sequencer #(.NB_DATA(N), .NB_OP(3)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_op(op),
    .i_data_a(a), .i_data_b(b), .i_flush(flush),
    .o_stall(stall), .o_busy(busy), .o_done(done),
    .o_result(result), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // {HI, LO} from ordinary 64-bit arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p = '0;
    case (o)
      MULT:  p = 64'(sx * sy);
      MULTU: p = {32'b0, x} * {32'b0, y};
      DIV: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      DIVU: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // called 1 time unit after an edge; returns 1 time unit after the accepting edge
  task automatic start_long(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check("accept_stall", stall, 0);
    tick();
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // counts edges after the accepting edge until o_done is seen
  task automatic wait_done(input int exp_lat, input string tag, input bit probe);
    int n = 0;
    while (!done && n < 200) begin
      if (probe && n == 3) begin
        start = 1'b1; op = MFLO;
        #1;
        check({tag, "_mf_stall"}, stall, 1);
        start = 1'b0;
      end
      tick();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic run_long(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [63:0] exp;
    int lat;
    exp = model(o, x, y);
    lat = ((o == DIV || o == DIVU) && y == 0) ? 1 : N + 1;
    start_long(o, x, y);
    wait_done(lat, tag, 1'b1);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
    check({tag, "_busy_clr"}, busy, 0);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] x);
    start = 1'b1; op = o; a = x;
    #1;
    check("mt_stall", stall, 0);
    tick();
    start = 1'b0;
    if (o == MTHI) m_hi = x; else m_lo = x;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  task automatic do_mf(input logic [2:0] o);
    start = 1'b1; op = o;
    #1;
    check("mf_stall", stall, 0);
    check(o == MFHI ? "mfhi" : "mflo", result, o == MFHI ? m_hi : m_lo);
    tick();
    start = 1'b0;
  endtask

  task automatic expect_quiet(input string tag);
    int seen = 0;
    repeat (40) begin
      tick();
      if (done || busy) seen++;
    end
    check({tag, "_quiet"}, seen, 0);
    check({tag, "_hi_kept"}, hi, m_hi);
    check({tag, "_lo_kept"}, lo, m_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    tick();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    run_long(MULT,  32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
    check("mult_const_lo", lo, 32'hFFFF_FFF1);
    run_long(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_const_hi", hi, 32'hFFFF_FFFE);
    run_long(DIVU,  32'd100, 32'd7, "divu_100_7");
    run_long(DIV,   32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_long(DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_const_lo", lo, 32'h8000_0000);
    run_long(DIV,   32'd1234, 32'd0, "div_by0");
    check("div_by0_const_hi", hi, 32'd1234);

    // flush mid-operation leaves HI/LO alone
    do_mt(MTHI, 32'hA5A5_A5A5);
    do_mf(MFHI);
    start_long(MULT, 32'd3, 32'd4);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    expect_quiet("flush");

    // flush together with a request: request dropped
    start = 1'b1; op = MTLO; a = 32'h1234_5678; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_mtlo_lo", lo, m_lo);

    // asynchronous reset mid-CALC
    start_long(MULT, 32'd3, 32'd4);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    check("rstmid_hi", hi, 0);
    check("rstmid_lo", lo, 0);
    check("rstmid_busy", busy, 0);
    rst = 1'b0;
    expect_quiet("rstmid");

    // back-to-back: next request accepted in the o_done cycle
    start_long(MULTU, 32'd6, 32'd7);
    wait_done(N + 1, "b2b_mul", 1'b0);
    start = 1'b1; op = MFLO;
    #1;
    check("b2b_mflo", result, 32'd42);
    check("b2b_mflo_stall", stall, 0);
    start_long(DIVU, 32'd42, 32'd6);
    wait_done(N + 1, "b2b_div", 1'b0);
    check("b2b_div_lo", lo, 32'd7);
    check("b2b_div_hi", hi, 32'd0);
    m_hi = hi_exp_dummy(32'd0); m_lo = 32'd7;
    tick();

    // random mix
    for (int i = 0; i < 30; i++) begin
      int r;
      logic [2:0] o;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        o = 3'($urandom_range(0, 3));
        run_long(o, pick(), pick(), $sformatf("rnd%0d_op%0d", i, o));
      end else if (r < 7) begin
        do_mt(($urandom_range(0, 1) != 0) ? MTHI : MTLO, $urandom);
      end else if (r < 9) begin
        do_mf(($urandom_range(0, 1) != 0) ? MFHI : MFLO);
      end else begin
        start = 1'b1; op = MTHI; a = ~m_hi; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check($sformatf("rnd%0d_flush_mthi", i), hi, m_hi);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [31:0] hi_exp_dummy(input logic [31:0] v);
    return v;
  endfunction

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer for the MIPS core, owning the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO requests from the EX stage and runs the long operations as NB_DATA-cycle iterative shift-add or restoring-divide sequences. It raises a stall to the pipeline while a long operation is in flight, and supports flushing for branch and exception squash. It sits beside the single-cycle ALU in EX.

## Interface
- NB_DATA, 32, operand and HI/LO width
- NB_OP, 3, request opcode width
- i_clock  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  request valid this cycle
- i_op  in  NB_OP  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO
- i_data_a  in  NB_DATA  rs operand: multiplicand, dividend, or MT source
- i_data_b  in  NB_DATA  rt operand: multiplier or divisor
- i_flush  in  1  abort any in-flight operation
- o_stall  out  1  combinational; i_start & (busy | i_op is MFHI/MFLO while a long op is pending)
- o_busy  out  1  registered; long operation in progress
- o_done  out  1  one-cycle pulse in the cycle after HI/LO are written by a long op
- o_result  out  NB_DATA  combinational; HI if i_op==MFHI, else LO
- o_hi, o_lo  out  NB_DATA  current HI/LO registers

## Operation
- States: IDLE, CALC, FIX.
  - IDLE: a request is accepted when i_start=1, o_stall=0 and i_flush=0.
- MTHI/MTLO:
  - HI or LO takes i_data_a at the accepting edge.
  - State stays IDLE.
- MFHI/MFLO:
  - o_result is valid combinationally in the same cycle.
  - No state change.
- MULT/MULTU/DIV/DIVU at the accepting edge:
  - Latch operand magnitudes. Signed ops take two's-complement absolute values; unsigned ops use the raw values.
  - Latch the sign flags.
  - Clear the iteration counter. Set busy. Go to CALC.
- Multiply in CALC, one iteration per cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper half of the 2·NB_DATA accumulator.
  - Shift the accumulator right 1, keeping the carry.
- Divide in CALC: restoring division, one quotient bit per cycle. Remainder is shifted left with the next dividend bit, then the divisor is trial-subtracted.
- Counter reaches NB_DATA-1 → FIX.
- FIX:
  - Apply sign correction.
    - Signed MULT: negate the 64-bit product if sign_a≠sign_b.
    - Signed DIV: negate the quotient if sign_a≠sign_b; negate the remainder if sign_a=1.
  - Write HI/LO (product: HI=upper, LO=lower; divide: LO=quotient, HI=remainder).
  - Go to IDLE and clear busy.
- Divide by zero (i_data_b==0, DIV or DIVU):
  - Skip CALC: accepting edge → FIX.
  - Write LO=all ones, HI=i_data_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0, from the natural magnitude path with no special case.
- Flush:
  - i_flush=1 forces IDLE at the next edge and clears busy.
  - HI/LO are unchanged and o_done is not asserted.
  - Flush together with i_start: flush wins and the request is not accepted.
- Requests presented while busy are stalled, not queued. The pipeline holds them until o_stall drops.

## Timing
- Reset, asynchronous: state=IDLE, HI=LO=0, counter=0, o_busy=0, o_done=0.
- Reset mid-operation discards the operation.
- Long op accepted at edge E0:
  - o_busy=1 after E0.
  - CALC occupies edges E1..E(NB_DATA). FIX is evaluated at edge E(NB_DATA+1).
  - After E(NB_DATA+1): HI/LO are updated, o_busy=0, o_done=1 for one cycle.
  - Total: NB_DATA+2 edges from acceptance to new HI/LO, i.e. 34 at NB_DATA=32.
- Divide-by-zero latency: HI/LO updated after E1; o_done is high in the following cycle.
- A new request may be accepted in the same cycle that o_done is high (back-to-back).
  - MFHI/MFLO in that cycle reads the new values.
- MT writes land at the accepting edge; MF in the next cycle returns the written value.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; o_done exactly 34 edges after acceptance; o_stall=1 for an MFLO issued during the operation.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 → LO=14, HI=2. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV 1234/0 → LO=0xFFFFFFFF, HI=1234; o_done after 2 edges.
- MTHI 0xA5A5A5A5 then MULT 3*4 flushed at cycle 10 → HI stays 0xA5A5A5A5, no o_done, o_busy=0 after the next edge. Repeat the operation with reset asserted mid-CALC → HI=LO=0.
- Back-to-back: MULTU 6*7, then DIVU 42/6 presented during the o_done cycle → LO=42 then LO=7; MFLO on the o_done cycle returns 42.
